// File: rtl/d_ff_two_bits.sv
// Enabled D flip-flop register with synchronous active-high reset.
// Delays the SDVM signed-digit select code (10 = +1, 01 = -1, 00 = 0) by one
// clock so the downstream pass/invert/zero mux sees a stable code. The code is
// stored verbatim (including 11); interpretation is left to the parent.
module d_ff_two_bits #(
    parameter int unsigned          WIDTH   = 2,
    parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    input  logic             clk,
    input  logic             en,
    input  logic             rst
);

    // Starts at RST_VAL so parent outputs begin at zero before the first reset edge.
    logic [WIDTH-1:0] q_q = RST_VAL;
    logic [WIDTH-1:0] q_d;

    // Next state: reset beats enable; with neither, hold (no decay).
    always_comb begin
        q_d = q_q;
        if (rst) begin
            q_d = RST_VAL;
        end else if (en) begin
            q_d = d;
        end
    end

    // State register; rst is only ever sampled here, on the rising edge.
    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    // Output comes straight from the flop, never combinationally from d.
    assign q = q_q;

endmodule

// File: tb/tb_d_ff_two_bits.sv
// Directed self-checking bench for d_ff_two_bits.
module tb_d_ff_two_bits;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] d;
    logic [1:0] q;

    int n_total = 0;
    int n_pass  = 0;

    d_ff_two_bits #(
        .WIDTH   (2),
        .RST_VAL (2'b00)
    ) dut (
        .d   (d),
        .q   (q),
        .clk (clk),
        .en  (en),
        .rst (rst)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b, expected %b", tag, got, exp);
        end
    endtask

    // Apply inputs, take one rising edge, settle 1 time unit past it.
    task automatic cyc(input logic r, input logic e, input logic [1:0] dv);
        rst = r;
        en  = e;
        d   = dv;
        @(posedge clk);
        #1;
    endtask

    logic [1:0] load_seq [4];
    logic [1:0] hold_seq [5];

    initial begin
        load_seq = '{2'b10, 2'b01, 2'b00, 2'b11};
        hold_seq = '{2'b10, 2'b00, 2'b11, 2'b10, 2'b00};
        rst = 1'b0;
        en  = 1'b0;
        d   = 2'b00;
        #1;
        check_eq("powerup", q, 2'b00);

        // Reset held for two edges with en=1, d=10.
        cyc(1'b1, 1'b1, 2'b10);
        check_eq("reset_edge1", q, 2'b00);
        cyc(1'b1, 1'b1, 2'b10);
        check_eq("reset_edge2", q, 2'b00);
        cyc(1'b0, 1'b1, 2'b10);
        check_eq("reset_release", q, 2'b10);

        // Load sequence, one cycle latency each.
        foreach (load_seq[i]) begin
            cyc(1'b0, 1'b1, load_seq[i]);
            check_eq($sformatf("load_%0d", i), q, load_seq[i]);
        end

        // d toggles mid-cycle: q must not follow until the edge.
        rst = 1'b0;
        en  = 1'b1;
        d   = 2'b01;
        #2;
        check_eq("no_bypass_a", q, 2'b11);
        d = 2'b10;
        #1;
        check_eq("no_bypass_b", q, 2'b11);
        @(posedge clk);
        #1;
        check_eq("mid_toggle_edge", q, 2'b10);

        // Hold with en low while d cycles.
        cyc(1'b0, 1'b1, 2'b01);
        check_eq("hold_load", q, 2'b01);
        foreach (hold_seq[i]) begin
            cyc(1'b0, 1'b0, hold_seq[i]);
            check_eq($sformatf("hold_%0d", i), q, 2'b01);
        end
        cyc(1'b0, 1'b1, 2'b10);
        check_eq("hold_release", q, 2'b10);

        // Reset wins over enable.
        cyc(1'b1, 1'b1, 2'b01);
        check_eq("rst_priority", q, 2'b00);
        cyc(1'b0, 1'b1, 2'b01);
        check_eq("after_rst_load", q, 2'b01);

        // Reset pulse between edges is never sampled.
        en  = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("rst_pulse_async", q, 2'b01);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_pulse_missed", q, 2'b01);

        // Reset with en low still clears a captured value.
        cyc(1'b0, 1'b1, 2'b11);
        check_eq("load_11", q, 2'b11);
        cyc(1'b1, 1'b0, 2'b10);
        check_eq("rst_en_low", q, 2'b00);
        cyc(1'b0, 1'b0, 2'b10);
        check_eq("idle_after_rst", q, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
